// File: rtl/axi4_lite_mm_bram_ctrl.sv
// axi4_lite_mm_bram_ctrl
//   Lets NUM_M AXI4-Lite masters (e.g. I-cache and D-cache) share one
//   single-port blk_mem_gen BRAM with one-cycle read latency. Requests are
//   arbitrated round-robin, and only one transaction is in flight at a time.
//   If the winning master has both a write and a read pending, the write is
//   served first.
//
// Ports
//   ACLK, ARESET              clock, asynchronous active-high reset
//   M_AR_* / M_R_*            per-master read address / read data channels
//   M_AW_* / M_W_* / M_B_*    per-master write address / data / response
//                             (master i uses slice i of every packed port;
//                              M_R_DATA, M_R_RESP and M_B_RESP are shared)
//   SLAVE_WE/ADDR/DIN/DOUT    BRAM port (word address, byte write enables)
//
// Optional feature
//   AXI_DECERR_EN  when defined, an address with any bit set above the BRAM
//                  word range returns DECERR (2'b11). Such writes are dropped,
//                  and such reads return zero data. When it is undefined,
//                  addresses wrap modulo BRAM_DEPTH.
module axi4_lite_mm_bram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BRAM_DEPTH  = 1024,
    parameter int BRAM_ADDR_W = $clog2(BRAM_DEPTH),
    parameter int NUM_M       = 2
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_M-1:0]          M_AR_VALID,
    output logic [NUM_M-1:0]          M_AR_READY,
    input  logic [NUM_M*ADDR_W-1:0]   M_AR_ADDR,
    output logic [NUM_M-1:0]          M_R_VALID,
    input  logic [NUM_M-1:0]          M_R_READY,
    output logic [DATA_W-1:0]         M_R_DATA,
    output logic [1:0]                M_R_RESP,
    input  logic [NUM_M-1:0]          M_AW_VALID,
    output logic [NUM_M-1:0]          M_AW_READY,
    input  logic [NUM_M*ADDR_W-1:0]   M_AW_ADDR,
    input  logic [NUM_M-1:0]          M_W_VALID,
    output logic [NUM_M-1:0]          M_W_READY,
    input  logic [NUM_M*DATA_W-1:0]   M_W_DATA,
    input  logic [NUM_M*DATA_W/8-1:0] M_W_STRB,
    output logic [NUM_M-1:0]          M_B_VALID,
    input  logic [NUM_M-1:0]          M_B_READY,
    output logic [1:0]                M_B_RESP,
    output logic [DATA_W/8-1:0]       SLAVE_WE,
    output logic [ADDR_W-1:0]         SLAVE_ADDR,
    output logic [DATA_W-1:0]         SLAVE_DIN,
    input  logic [DATA_W-1:0]         SLAVE_DOUT
);
    localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_RESP = 2'd2;
    localparam logic [1:0] WR_RESP = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  gnt;
    logic              rd_err_q;

    logic [NUM_M-1:0]  wr_req;
    logic [NUM_M-1:0]  rd_req;
    logic              found;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  win_next;
    logic              win_is_wr;
    logic              grant;
    logic [ADDR_W-1:0] aw_addr_sel;
    logic [ADDR_W-1:0] ar_addr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] w_data_sel;
    logic [STRB_W-1:0] w_strb_sel;
    logic              addr_err;
    logic              unused_addr_bits;

    // A write needs AW and W together; both are accepted in the same cycle.
    assign wr_req = M_AW_VALID & M_W_VALID;
    assign rd_req = M_AR_VALID;

    // Round-robin search starting at rr. The first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            cand = IDX_W'((32'(rr) + k) % 32'(NUM_M));
            if (!found && (wr_req[cand] || rd_req[cand])) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_next    = (win == IDX_W'(NUM_M - 1)) ? '0 : win + IDX_W'(1);
    assign win_is_wr   = wr_req[win];
    assign grant       = (state == IDLE) && found && !ARESET;
    assign aw_addr_sel = M_AW_ADDR[win*ADDR_W +: ADDR_W];
    assign ar_addr_sel = M_AR_ADDR[win*ADDR_W +: ADDR_W];
    assign addr_sel    = win_is_wr ? aw_addr_sel : ar_addr_sel;
    assign w_data_sel  = M_W_DATA[win*DATA_W +: DATA_W];
    assign w_strb_sel  = M_W_STRB[win*STRB_W +: STRB_W];

`ifdef AXI_DECERR_EN
    assign addr_err = |addr_sel[ADDR_W-1:BRAM_ADDR_W+2];
`else
    assign addr_err = 1'b0;
`endif

    // Byte-lane bits, and the upper bits when addresses simply wrap.
    assign unused_addr_bits = ^{addr_sel[1:0], addr_sel[ADDR_W-1:BRAM_ADDR_W+2]};

    // The address phase is combinational in the grant cycle. This lets the
    // BRAM latch a write at the grant edge and start a read in that same cycle.
    always_comb begin
        M_AR_READY = '0;
        M_AW_READY = '0;
        M_W_READY  = '0;
        SLAVE_WE   = '0;
        SLAVE_ADDR = '0;
        SLAVE_DIN  = '0;
        M_R_VALID  = '0;
        M_B_VALID  = '0;
        if (grant) begin
            SLAVE_ADDR = ADDR_W'(addr_sel[BRAM_ADDR_W+1:2]);
            if (win_is_wr) begin
                M_AW_READY[win] = 1'b1;
                M_W_READY[win]  = 1'b1;
                SLAVE_DIN       = w_data_sel;
                SLAVE_WE        = addr_err ? '0 : w_strb_sel;
            end else begin
                M_AR_READY[win] = 1'b1;
            end
        end
        if (state == RD_RESP) M_R_VALID[gnt] = 1'b1;
        if (state == WR_RESP) M_B_VALID[gnt] = 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= IDLE;
            rr       <= '0;
            gnt      <= '0;
            rd_err_q <= 1'b0;
            M_R_DATA <= '0;
            M_R_RESP <= 2'b00;
            M_B_RESP <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt <= win;
                        rr  <= win_next;
                        if (win_is_wr) begin
                            M_B_RESP <= addr_err ? 2'b11 : 2'b00;
                            state    <= WR_RESP;
                        end else begin
                            rd_err_q <= addr_err;
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    M_R_DATA <= rd_err_q ? '0 : SLAVE_DOUT;
                    M_R_RESP <= rd_err_q ? 2'b11 : 2'b00;
                    state    <= RD_RESP;
                end
                RD_RESP: if (M_R_READY[gnt]) state <= IDLE;
                WR_RESP: if (M_B_READY[gnt]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_mm_bram_ctrl.sv
// Testbench for axi4_lite_mm_bram_ctrl (NUM_M=2, 32-bit data, 1024 words).
// A transaction-level reference model decides, on every cycle, what the
// outputs must be. When the block is free, it grants the first requester
// in round-robin order, with writes before reads. Read data appears two
// cycles after the grant and a write response one cycle after. The
// response then holds until the master accepts it.
module tb_axi4_lite_mm_bram_ctrl;
    localparam int NM    = 2;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int BAW   = 10;
    localparam int SW    = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0]    ar_valid, ar_ready, r_valid, r_ready;
    logic [NM-1:0]    aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [NM*AW-1:0] ar_addr, aw_addr;
    logic [NM*DW-1:0] w_data;
    logic [NM*SW-1:0] w_strb;
    logic [DW-1:0]    r_data, s_din, s_dout;
    logic [1:0]       r_resp, b_resp;
    logic [SW-1:0]    s_we;
    logic [AW-1:0]    s_addr;

    axi4_lite_mm_bram_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .BRAM_DEPTH(DEPTH), .BRAM_ADDR_W(BAW), .NUM_M(NM)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .M_AR_VALID(ar_valid), .M_AR_READY(ar_ready), .M_AR_ADDR(ar_addr),
        .M_R_VALID(r_valid), .M_R_READY(r_ready), .M_R_DATA(r_data), .M_R_RESP(r_resp),
        .M_AW_VALID(aw_valid), .M_AW_READY(aw_ready), .M_AW_ADDR(aw_addr),
        .M_W_VALID(w_valid), .M_W_READY(w_ready), .M_W_DATA(w_data), .M_W_STRB(w_strb),
        .M_B_VALID(b_valid), .M_B_READY(b_ready), .M_B_RESP(b_resp),
        .SLAVE_WE(s_we), .SLAVE_ADDR(s_addr), .SLAVE_DIN(s_din), .SLAVE_DOUT(s_dout)
    );

    // BRAM model: read-first, one-cycle read latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < SW; b++)
            if (s_we[b]) ram[s_addr[BAW-1:0]][8*b +: 8] <= s_din[8*b +: 8];
        s_dout <= ram[s_addr[BAW-1:0]];
    end

    // Reference model state
    logic [DW-1:0] mmem [DEPTH];
    int            m_rr, m_who, m_age;
    bit            m_busy, m_is_wr;
    logic [DW-1:0] m_data;
    logic [1:0]    m_resp;

    // Bookkeeping
    int            n_checks = 0, n_fail = 0, cyc = 0;
    int            glog[$];
    int            g_cyc, rv_cyc, bv_cyc;
    int            rhs_cnt[NM], bhs_cnt[NM];
    logic [DW-1:0] cap_rdata[NM];
    logic [1:0]    cap_rresp[NM], cap_bresp[NM];
    logic [NM-1:0] prev_rv = '0, prev_bv = '0, hs_ar, hs_aw;
    bit            gen_en = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: never

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit addr_err(input logic [AW-1:0] a);
`ifdef AXI_DECERR_EN
        return (a >> (BAW + 2)) != 0;
`else
        return a[0] & 1'b0;
`endif
    endfunction

    task automatic check_cycle();
        logic [NM-1:0] e_arr, e_awr, e_rv, e_bv;
        logic [SW-1:0] e_we, st;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            win, c, idx;
        bit            err;
        e_arr = '0; e_awr = '0; e_rv = '0; e_bv = '0; e_we = '0;
        cyc++;
        for (int i = 0; i < NM; i++) begin
            if (ar_ready[i] && ar_valid[i]) begin glog.push_back(i); g_cyc = cyc; end
            if (aw_ready[i] && aw_valid[i] && w_valid[i]) begin glog.push_back(100 + i); g_cyc = cyc; end
            if (r_valid[i] && !prev_rv[i]) rv_cyc = cyc;
            if (b_valid[i] && !prev_bv[i]) bv_cyc = cyc;
            if (r_valid[i] && r_ready[i]) begin rhs_cnt[i]++; cap_rdata[i] = r_data; cap_rresp[i] = r_resp; end
            if (b_valid[i] && b_ready[i]) begin bhs_cnt[i]++; cap_bresp[i] = b_resp; end
        end
        prev_rv = r_valid;
        prev_bv = b_valid;
        if (rst) begin
            chk("rst_ar_ready", ar_ready, 0); chk("rst_aw_ready", aw_ready, 0);
            chk("rst_w_ready", w_ready, 0);   chk("rst_r_valid", r_valid, 0);
            chk("rst_b_valid", b_valid, 0);   chk("rst_r_data", r_data, 0);
            chk("rst_r_resp", r_resp, 0);     chk("rst_b_resp", b_resp, 0);
            chk("rst_slave_we", s_we, 0);     chk("rst_slave_addr", s_addr, 0);
            chk("rst_slave_din", s_din, 0);
            m_busy = 0; m_rr = 0;
            return;
        end
        if (!m_busy) begin
            win = -1;
            for (int k = 0; k < NM; k++) begin
                c = (m_rr + k) % NM;
                if (win < 0 && ((aw_valid[c] && w_valid[c]) || ar_valid[c])) win = c;
            end
            if (win >= 0) begin
                m_is_wr = aw_valid[win] && w_valid[win];
                a   = m_is_wr ? aw_addr[win*AW +: AW] : ar_addr[win*AW +: AW];
                idx = int'(a[BAW+1:2]);
                err = addr_err(a);
                m_resp = err ? 2'b11 : 2'b00;
                if (m_is_wr) begin
                    e_awr[win] = 1'b1;
                    wd = w_data[win*DW +: DW];
                    st = w_strb[win*SW +: SW];
                    e_we = err ? '0 : st;
                    chk("slave_din", s_din, wd);
                    if (!err)
                        for (int b = 0; b < SW; b++)
                            if (st[b]) mmem[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e_arr[win] = 1'b1;
                    m_data = err ? '0 : mmem[idx];
                end
                chk("slave_addr", s_addr, idx);
                m_busy = 1; m_age = 0; m_who = win; m_rr = (win + 1) % NM;
            end
        end else begin
            m_age++;
            if (!m_is_wr && m_age >= 2) e_rv[m_who] = 1'b1;
            if (m_is_wr && m_age >= 1) e_bv[m_who] = 1'b1;
            if (e_rv != 0) begin
                chk("r_data", r_data, m_data);
                chk("r_resp", r_resp, m_resp);
                if (r_ready[m_who]) m_busy = 0;
            end
            if (e_bv != 0) begin
                chk("b_resp", b_resp, m_resp);
                if (b_ready[m_who]) m_busy = 0;
            end
        end
        chk("ar_ready", ar_ready, e_arr);
        chk("aw_ready", aw_ready, e_awr);
        chk("w_ready", w_ready, e_awr);
        chk("r_valid", r_valid, e_rv);
        chk("b_valid", b_valid, e_bv);
        chk("slave_we", s_we, e_we);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (AW'(1) << $urandom_range(12, 31));
        return a;
    endfunction

    // One clock: check at the falling edge, then update masters just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_cycle();
        hs_ar = ar_valid & ar_ready;
        hs_aw = aw_valid & w_valid & aw_ready;
        @(posedge clk);
        #1;
        ar_valid &= ~hs_ar;
        aw_valid &= ~hs_aw;
        w_valid  &= ~hs_aw;
        if (gen_en)
            for (int i = 0; i < NM; i++) begin
                if (!ar_valid[i] && $urandom_range(0, 99) < 25) begin
                    ar_valid[i] = 1'b1; ar_addr[i*AW +: AW] = rand_addr();
                end
                if (!aw_valid[i] && $urandom_range(0, 99) < 25) begin
                    aw_valid[i] = 1'b1; w_valid[i] = 1'b1;
                    aw_addr[i*AW +: AW] = rand_addr();
                    w_data[i*DW +: DW]  = $urandom;
                    w_strb[i*SW +: SW]  = SW'($urandom_range(0, 15));
                end
            end
        case (rdy_mode)
            0:       begin r_ready = '1; b_ready = '1; end
            1:       begin r_ready = NM'($urandom); b_ready = NM'($urandom); end
            default: begin r_ready = '0; b_ready = '0; end
        endcase
    endtask

    task automatic wait_done(input int m, input bit is_wr, input string nm);
        int start, n;
        start = is_wr ? bhs_cnt[m] : rhs_cnt[m];
        n = 0;
        while ((is_wr ? bhs_cnt[m] : rhs_cnt[m]) == start && n < 50) begin cycle(); n++; end
        if (n >= 50) begin n_checks++; n_fail++; $display("FAIL %s: no response within 50 cycles", nm); end
    endtask

    task automatic do_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        aw_addr[m*AW +: AW] = a; w_data[m*DW +: DW] = d; w_strb[m*SW +: SW] = s;
        aw_valid[m] = 1'b1; w_valid[m] = 1'b1;
        wait_done(m, 1, "write_timeout");
    endtask

    task automatic do_read(input int m, input logic [AW-1:0] a);
        ar_addr[m*AW +: AW] = a; ar_valid[m] = 1'b1;
        wait_done(m, 0, "read_timeout");
    endtask

    task automatic dual_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int s0, s1, n;
        s0 = rhs_cnt[0]; s1 = rhs_cnt[1]; n = 0;
        ar_addr[0 +: AW] = a0; ar_addr[AW +: AW] = a1; ar_valid = '1;
        while ((rhs_cnt[0] == s0 || rhs_cnt[1] == s1) && n < 60) begin cycle(); n++; end
        if (n >= 60) begin n_checks++; n_fail++; $display("FAIL dual_read_timeout: reads incomplete"); end
    endtask

    initial begin
        int n;
        ar_valid = '0; aw_valid = '0; w_valid = '0; r_ready = '1; b_ready = '1;
        ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;
        for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; mmem[i] = '0; end
        for (int i = 0; i < NM; i++) begin rhs_cnt[i] = 0; bhs_cnt[i] = 0; end
        m_busy = 0; m_rr = 0;

        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // Simultaneous reads from both masters: grants alternate starting at 0.
        glog.delete();
        repeat (4) dual_read(32'h0, 32'h4);
        chk("rr_log_len", glog.size(), 8);
        for (int j = 0; j < 8 && j < glog.size(); j++) chk("rr_grant_order", glog[j], j % 2);

        // Full write then read-back, with latency pinned by hand.
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_b_latency", bv_cyc - g_cyc, 1);
        chk("wr_b_resp", cap_bresp[0], 2'b00);
        do_read(0, 32'h10);
        chk("rd_r_latency", rv_cyc - g_cyc, 2);
        chk("rd_deadbeef", cap_rdata[0], 32'hDEADBEEF);
        chk("model_deadbeef", m_data, 32'hDEADBEEF);

        // Partial byte-strobe write.
        do_write(0, 32'h40, 32'h11223344, 4'hF);
        do_write(0, 32'h40, 32'h0000AB00, 4'b0010);
        do_read(0, 32'h40);
        chk("partial_strb", cap_rdata[0], 32'h1122AB44);

        // Same master issues a write and a read to the same address together.
        glog.delete();
        aw_addr[AW +: AW] = 32'h20; w_data[DW +: DW] = 32'h5A5A1234; w_strb[SW +: SW] = 4'hF;
        ar_addr[AW +: AW] = 32'h20;
        aw_valid[1] = 1'b1; w_valid[1] = 1'b1; ar_valid[1] = 1'b1;
        wait_done(1, 0, "wr_rd_timeout");
        chk("wr_before_rd_0", glog.size() > 0 ? glog[0] : -1, 101);
        chk("wr_before_rd_1", glog.size() > 1 ? glog[1] : -1, 1);
        chk("store_then_load", cap_rdata[1], 32'h5A5A1234);

        // Out-of-range address.
        do_write(0, 32'h0, 32'hCAFEF00D, 4'hF);
        do_read(0, 32'h0000_2000);
`ifdef AXI_DECERR_EN
        chk("oor_data", cap_rdata[0], 32'h0);
        chk("oor_resp", cap_rresp[0], 2'b11);
`else
        chk("wrap_data", cap_rdata[0], 32'hCAFEF00D);
        chk("wrap_resp", cap_rresp[0], 2'b00);
`endif

        // Randomised traffic with random back-pressure.
        gen_en = 1; rdy_mode = 1;
        repeat (3000) cycle();
        gen_en = 0; rdy_mode = 0;
        n = 0;
        while (((ar_valid | aw_valid) != 0 || m_busy) && n < 200) begin cycle(); n++; end
        if (n >= 200) begin n_checks++; n_fail++; $display("FAIL drain_timeout: traffic did not drain"); end
        cycle();

        // Reset while read data is waiting on a stalled master.
        rdy_mode = 2;
        ar_addr[0 +: AW] = 32'h10; ar_valid[0] = 1'b1;
        n = 0;
        while (!prev_rv[0] && n < 20) begin cycle(); n++; end
        chk("pre_reset_r_valid", prev_rv[0], 1'b1);
        #2;
        rst = 1'b1;
        ar_valid = '0; aw_valid = '0; w_valid = '0;
        #1;
        chk("reset_drops_r_valid", r_valid, 0);
        chk("reset_slave_we", s_we, 0);
        repeat (2) cycle();
        rst = 1'b0; rdy_mode = 0;
        cycle();
        glog.delete();
        dual_read(32'h40, 32'h20);
        chk("post_rst_first_grant", glog.size() > 0 ? glog[0] : -1, 0);
        chk("post_rst_second_grant", glog.size() > 1 ? glog[1] : -1, 1);
        chk("post_rst_r_resp", cap_rresp[0], 2'b00);
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
